mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255, max cycles a granted access waits for mem_ready before abort.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_req / if_addr  input  1 / 32  instruction-fetch read request and word address.
REQ-005 if_gnt / if_rvalid / if_rdata / if_err  output  1 / 1 / 32 / 1  fetch accepted, response pulse, read data, timeout flag.
REQ-006 d_req / d_we / d_be / d_addr / d_wdata  input  1 / 1 / 4 / 32 / 32  data-port request, write enable, byte enables, address, write data.
REQ-007 d_gnt / d_rvalid / d_rdata / d_err  output  1 / 1 / 32 / 1  data accepted, response pulse, read data, timeout flag.
REQ-008 mem_req / mem_we / mem_be / mem_addr / mem_wdata  output  1 / 1 / 4 / 32 / 32  shared single-port memory request bus.
REQ-009 mem_ready / mem_rdata  input  1 / 32  memory completion strobe and read data, valid in the same cycle.

Function
REQ-010 FSM states IDLE, BUSY_IF, BUSY_D; IDLE on reset.
REQ-011 In IDLE, the winner's gnt SHALL assert combinationally in the cycle a request is accepted; its request fields are registered on that edge and the FSM enters BUSY_IF or BUSY_D.
REQ-012 If neither port requests in IDLE, all gnt outputs SHALL be 0 and the state SHALL remain IDLE.
REQ-013 In BUSY_*, mem_req=1 with registered fields held stable; fetch accesses drive mem_we=0, mem_be=4'hF.
REQ-014 mem_ready=1 in BUSY_* SHALL register mem_rdata into the owner's rdata, pulse the owner's rvalid for exactly one cycle on the next cycle (err=0), and return to IDLE.
REQ-015 Data writes SHALL also produce an rvalid pulse as completion; rdata content is don't-care.
REQ-016 Minimum access latency: gnt cycle N, mem_req from N+1, rvalid at cycle after mem_ready; one IDLE bubble between accesses.
REQ-017 An 8-bit wait counter SHALL clear on entry to BUSY_* and increment each BUSY_* cycle without mem_ready.
REQ-018 On counter == TIMEOUT, the access SHALL abort: mem_req drops, owner's rvalid and err pulse together next cycle, and the FSM returns to IDLE.
REQ-019 gnt and rvalid SHALL never assert for both ports in the same cycle; rvalid only to the current owner.
REQ-020 req inputs are ignored in BUSY_*; requesters hold req until gnt.

Reset
REQ-021 rst SHALL immediately force IDLE and 0 on all outputs (gnt, rvalid, err, rdata, mem_*), clear the counter, and reset the arbitration pointer to "data last".
REQ-022 Reset mid-access SHALL drop mem_req within the same cycle and produce no rvalid for the aborted access.

Configuration
REQ-023 Macro MEM_ARB_RR_EN defined: simultaneous requests in IDLE SHALL alternate by round-robin pointer (last-granted port loses); the pointer updates on every grant.
REQ-024 MEM_ARB_RR_EN undefined: fixed priority, data port always wins; no pointer register.

Structure
REQ-025 Shared package mem_arb_pkg SHALL hold the FSM state enum, port-ID constants (PORT_IF, PORT_D), and the default TIMEOUT.
REQ-026 Winner selection SHALL be one sub-module arb_pick (two requests plus pointer in, one-hot grant out).
REQ-027 Counter, FSM, and response registers remain in mem_arbiter.

Verification
REQ-028 Fetch only: if_req=1, if_addr=32'h100; mem_ready after 2 cycles with mem_rdata=32'h00500093 -> if_gnt pulse, mem_addr=32'h100, if_rvalid pulse with if_rdata=32'h00500093, if_err=0.
REQ-029 Simultaneous if_req and d_req (read 32'h2000), macro undefined -> d_gnt first, fetch granted after data rvalid plus one IDLE cycle.
REQ-030 Same stimulus, MEM_ARB_RR_EN defined, three back-to-back contention rounds after reset -> grant order IF, D, IF.
REQ-031 Data write d_be=4'b0011, d_wdata=32'hDEADBEEF, mem_ready never asserted, TIMEOUT=4 -> mem_req high for 5 cycles, then d_rvalid=1 and d_err=1 for one cycle, FSM IDLE.
REQ-032 rst asserted while in BUSY_D -> mem_req=0 in the same cycle, no d_rvalid afterward, next if_req granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

  // Port IDs double as bit positions in the one-hot grant vector.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection for the arbiter. MEM_ARB_RR_EN selects round-robin on contention,
// otherwise the data port has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
`ifdef MEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      // The port granted most recently loses a tie.
      if (last == PORT_D) gnt[PORT_IF] = 1'b1;
      else                gnt[PORT_D]  = 1'b1;
`else
      gnt[PORT_D] = 1'b1;
`endif
    end else if (d_req) begin
      gnt[PORT_D] = 1'b1;
    end else if (if_req) begin
      gnt[PORT_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory, with a
// wait timeout. Define MEM_ARB_RR_EN for round-robin arbitration (default: data wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        if_rvalid_q, d_rvalid_q, if_err_q, d_err_q;
  logic [1:0]  pick, gnt_vec;
  logic        idle, busy, expired;

  assign idle    = (state_q == StIdle);
  assign busy    = ~idle;
  assign expired = busy && !mem_ready && (cnt_q == TIMEOUT);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_q <= PORT_D;
    else if (|gnt_vec) last_q <= gnt_vec[PORT_D] ? PORT_D : PORT_IF;
  end

  arb_pick u_pick (.if_req(if_req), .d_req(d_req), .last(last_q), .gnt(pick));
`else
  arb_pick u_pick (.if_req(if_req), .d_req(d_req), .gnt(pick));
`endif

  // Grants are combinational, so gate them with reset to keep outputs quiet during it.
  assign gnt_vec = (idle && !rst) ? pick : 2'b00;
  assign if_gnt  = gnt_vec[PORT_IF];
  assign d_gnt   = gnt_vec[PORT_D];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (gnt_vec[PORT_D])       state_d = StBusyD;
        else if (gnt_vec[PORT_IF]) state_d = StBusyIf;
      end
      StBusyIf, StBusyD: begin
        if (mem_ready || expired) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if (gnt_vec[PORT_D]) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        be_q    <= d_be;
        wdata_q <= d_wdata;
        cnt_q   <= '0;
      end else if (gnt_vec[PORT_IF]) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        be_q    <= 4'hF;
        wdata_q <= '0;
        cnt_q   <= '0;
      end else if (busy) begin
        if (mem_ready) begin
          if (state_q == StBusyD) begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end
        end else if (expired) begin
          if (state_q == StBusyD) begin
            d_rvalid_q <= 1'b1;
            d_err_q    <= 1'b1;
          end else begin
            if_rvalid_q <= 1'b1;
            if_err_q    <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_be    = busy ? be_q : 4'h0;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, random transactions.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  logic last_port;

  typedef struct {
    string       name;
    logic        ri;
    logic        rd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          delay;     // busy cycle in which mem_ready rises; -1 = never
    logic        exp_port;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Reference arbitration: a lone requester wins; ties go to data (fixed) or to
  // whichever port was not granted last (round-robin).
  function automatic logic model_pick(input logic ri, input logic rd);
    if (ri && rd) begin
`ifdef MEM_ARB_RR_EN
      return (last_port == PORT_D) ? PORT_IF : PORT_D;
`else
      return PORT_D;
`endif
    end
    return rd ? PORT_D : PORT_IF;
  endfunction

  function automatic logic [31:0] onehot(input logic port);
    return (port == PORT_D) ? 32'd1 : 32'd2;   // {if, d} ordering
  endfunction

  // One complete access starting in IDLE: grant, busy phase, response pulse.
  task automatic xact(input string tag, input logic ri, input logic rd, input logic we,
                      input logic [3:0] be, input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] wd, input logic [31:0] rdat, input int delay,
                      input logic port, input logic exp_err);
    int  k;
    bit  done;
    if_req = ri; d_req = rd; d_we = we; d_be = be; if_addr = ia; d_addr = da; d_wdata = wd;
    #1;
    chk({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, onehot(port));
    last_port = port;
    cyc();
    // Scramble the request fields to show the bus uses the registered copy.
    if_addr = ~ia; d_addr = ~da; d_wdata = ~wd; d_we = ~we; d_be = ~be;
    done = 1'b0;
    k = 0;
    while (!done) begin
      if_req = 1'($urandom_range(0, 1));
      d_req  = 1'($urandom_range(0, 1));
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rdat : $urandom;
      #1;
      chk({tag, "_mreq"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_maddr"}, mem_addr, (port == PORT_D) ? da : ia);
      chk({tag, "_mwe"}, {31'd0, mem_we}, (port == PORT_D) ? {31'd0, we} : 32'd0);
      chk({tag, "_mbe"}, {28'd0, mem_be}, (port == PORT_D) ? {28'd0, be} : 32'hF);
      if (port == PORT_D) chk({tag, "_mwdata"}, mem_wdata, wd);
      chk({tag, "_busy_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
      done = (k == delay) || (k == int'(TO));
      k++;
      cyc();
    end
    mem_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #1;
    chk({tag, "_mreq_end"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, if_rvalid, d_rvalid}, onehot(port));
    chk({tag, "_err"}, {30'd0, if_err, d_err}, exp_err ? onehot(port) : 32'd0);
    if (!exp_err && !(port == PORT_D && we))
      chk({tag, "_rdata"}, (port == PORT_D) ? d_rdata : if_rdata, rdat);
    cyc();
    #1;
    chk({tag, "_rv_pulse"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    last_port = PORT_D;
    cyc();
    rst = 1'b0;
  endtask

  vec_t vecs[6];
  logic ord_exp[3];

  initial begin
    vecs[0] = '{"fetch",   1, 0, 0, 4'h0, 32'h100,      32'h0,    32'h0,        32'h00500093, 2,
                PORT_IF, 0};
    vecs[1] = '{"dread",   0, 1, 0, 4'hF, 32'h0,        32'h2000, 32'h0,        32'h12345678, 0,
                PORT_D, 0};
    vecs[2] = '{"dwrite",  0, 1, 1, 4'h3, 32'h0,        32'h44,   32'hDEADBEEF, 32'h0,        1,
                PORT_D, 0};
    vecs[3] = '{"dwr_to",  0, 1, 1, 4'h3, 32'h0,        32'h80,   32'hDEADBEEF, 32'h0,        -1,
                PORT_D, 1};
    vecs[4] = '{"if_to",   1, 0, 0, 4'h0, 32'h200,      32'h0,    32'h0,        32'h0,        -1,
                PORT_IF, 1};
    vecs[5] = '{"fetch3",  1, 0, 0, 4'h0, 32'hFFFFFFFC, 32'h0,    32'h0,        32'hA5A5A5A5, 3,
                PORT_IF, 0};
`ifdef MEM_ARB_RR_EN
    ord_exp[0] = PORT_IF; ord_exp[1] = PORT_D; ord_exp[2] = PORT_IF;
`else
    ord_exp[0] = PORT_D;  ord_exp[1] = PORT_D; ord_exp[2] = PORT_D;
`endif

    // Reset: outputs quiet even with both ports requesting.
    idle_inputs();
    rst = 1'b1;
    last_port = PORT_D;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h1234; d_addr = 32'h5678; d_be = 4'hF;
    cyc(); cyc();
    #1;
    chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
    chk("rst_mreq", {31'd0, mem_req}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mbe_we", {27'd0, mem_be, mem_we}, 32'd0);
    chk("rst_rvalid_err", {28'd0, if_rvalid, d_rvalid, if_err, d_err}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    idle_inputs();
    rst = 1'b0;
    cyc();
    #1;
    chk("idle_no_req_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
    cyc();
    chk("idle_stays", {31'd0, mem_req}, 32'd0);

    // Directed table.
    foreach (vecs[i])
      xact(vecs[i].name, vecs[i].ri, vecs[i].rd, vecs[i].we, vecs[i].be, vecs[i].ia,
           vecs[i].da, vecs[i].wd, vecs[i].rdat, vecs[i].delay, vecs[i].exp_port,
           vecs[i].exp_err);

    // Contention: loser holds its request and is granted in the IDLE bubble.
    begin
      logic w;
      if_addr = 32'h100; if_req = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000;
      #1;
      w = model_pick(1'b1, 1'b1);
      chk("cont_first", {30'd0, if_gnt, d_gnt}, onehot(w));
      last_port = w;
      cyc();
      if (w == PORT_D) d_req = 1'b0; else if_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'hC0DE0001;
      #1;
      chk("cont_addr1", mem_addr, (w == PORT_D) ? 32'h2000 : 32'h100);
      chk("cont_hold", {30'd0, if_gnt, d_gnt}, 32'd0);
      cyc();
      mem_ready = 1'b0;
      #1;
      chk("cont_rv1", {30'd0, if_rvalid, d_rvalid}, onehot(w));
      chk("cont_second", {30'd0, if_gnt, d_gnt}, onehot(~w));
      last_port = ~w;
      cyc();
      if_req = 1'b0; d_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'hC0DE0002;
      #1;
      chk("cont_addr2", mem_addr, (w == PORT_D) ? 32'h100 : 32'h2000);
      cyc();
      mem_ready = 1'b0;
      #1;
      chk("cont_rv2", {30'd0, if_rvalid, d_rvalid}, onehot(~w));
      chk("cont_rdata2", (w == PORT_D) ? if_rdata : d_rdata, 32'hC0DE0002);
      cyc();
    end

    // Three contention rounds straight after reset.
    do_reset();
    for (int i = 0; i < 3; i++)
      xact($sformatf("rr%0d", i), 1'b1, 1'b1, 1'b0, 4'hF, 32'h300 + i, 32'h4000 + i,
           32'h0, 32'h7000 + i, 0, ord_exp[i], 1'b0);

    // Reset in the middle of a data access.
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h3000;
    #1;
    chk("mid_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
    cyc();
    d_req = 1'b0;
    cyc();
    #1;
    chk("mid_busy", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_mreq", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_maddr", mem_addr, 32'd0);
    last_port = PORT_D;
    cyc();
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_no_rvalid", {30'd0, d_rvalid, d_err}, 32'd0);
      cyc();
    end
    mem_ready = 1'b0;
    xact("after_rst", 1'b1, 1'b0, 1'b0, 4'h0, 32'h500, 32'h0, 32'h0, 32'h600D600D, 1,
         PORT_IF, 1'b0);

    // Random transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic ri, rd, we, p;
      int   dly;
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      we = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 5);
      if (dly >= int'(TO)) dly = -1;
      p = model_pick(ri, rd);
      xact($sformatf("rnd%0d", i), ri, rd, we, 4'($urandom), $urandom, $urandom, $urandom,
           $urandom, dly, p, dly < 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
